// File: rtl/slot_pair_arbiter_if.sv
// Slot-pair arbiter bus: boundary pulse, requests, lengths and grant outputs.
// The master side drives requests; the slave side is the arbiter.
interface slot_pair_arbiter_if;
    logic       pair_endp;
    logic [2:0] req;
    logic [1:0] len0;
    logic [1:0] len1;
    logic [1:0] len2;
    logic [3:0] regi_starve_lim;
    logic [2:0] gnt;
    logic       gnt_start_p;
    logic [1:0] pairs_left;
    logic       busy;

    modport master (
        output pair_endp, req, len0, len1, len2, regi_starve_lim,
        input  gnt, gnt_start_p, pairs_left, busy
    );

    modport slave (
        input  pair_endp, req, len0, len1, len2, regi_starve_lim,
        output gnt, gnt_start_p, pairs_left, busy
    );
endinterface

// File: rtl/slot_pair_arbiter.sv
// Slot-pair timeline arbiter: connection, page scan and inquiry scan.
// Define SLOT_ARB_STARVE_EN to add scan starvation counters and urgency.
module slot_pair_arbiter (
    input  logic               clk_6M,
    input  logic               rstz,
    slot_pair_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [2:0] gnt_q;
    logic [1:0] pl_q;
    logic       start_q;
    logic       rr;

    logic       urg1;
    logic       urg2;
    logic [2:0] tie;
    logic [2:0] win;
    logic [1:0] win_len;
    logic       rel;
    logic [2:0] nxt_gnt;

    assign bus.gnt         = gnt_q;
    assign bus.gnt_start_p = start_q;
    assign bus.pairs_left  = pl_q;
    assign bus.busy        = |gnt_q;

`ifdef SLOT_ARB_STARVE_EN
    logic [3:0] cnt1;
    logic [3:0] cnt2;

    // Urgency uses the counts from before this boundary's update.
    always_comb begin
        urg1 = 1'b0;
        urg2 = 1'b0;
        if (bus.regi_starve_lim != 4'd0) begin
            urg1 = bus.req[1] && (cnt1 >= bus.regi_starve_lim);
            urg2 = bus.req[2] && (cnt2 >= bus.regi_starve_lim);
        end
    end
`else
    logic [3:0] unused_lim;
    assign unused_lim = bus.regi_starve_lim;
    assign urg1 = 1'b0;
    assign urg2 = 1'b0;
`endif

    always_comb begin
        tie = rr ? 3'b100 : 3'b010;
        win = 3'b000;
        if (urg1 && urg2)
            win = tie;
        else if (urg1)
            win = 3'b010;
        else if (urg2)
            win = 3'b100;
        else if (bus.req[0])
            win = 3'b001;
        else if (bus.req[1] && bus.req[2])
            win = tie;
        else if (bus.req[1])
            win = 3'b010;
        else if (bus.req[2])
            win = 3'b100;
    end

    always_comb begin
        win_len = 2'd0;
        case (1'b1)
            win[0]:  win_len = bus.len0;
            win[1]:  win_len = bus.len1;
            win[2]:  win_len = bus.len2;
            default: win_len = 2'd0;
        endcase
    end

    // An expired owner or one that dropped its request gives up the pair.
    always_comb begin
        rel = (state == IDLE) || (pl_q == 2'd0)
           || ((bus.req & gnt_q) == 3'b000);
        nxt_gnt = rel ? win : gnt_q;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state   <= IDLE;
            gnt_q   <= 3'b000;
            pl_q    <= 2'd0;
            start_q <= 1'b0;
            rr      <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (bus.pair_endp) begin
                if (rel) begin
                    gnt_q   <= win;
                    pl_q    <= win_len;
                    start_q <= |win;
                    state   <= (|win) ? GRANT : IDLE;
                    if (win[1])
                        rr <= 1'b1;
                    else if (win[2])
                        rr <= 1'b0;
                end else begin
                    pl_q <= pl_q - 2'd1;
                end
            end
        end
    end

`ifdef SLOT_ARB_STARVE_EN
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            cnt1 <= 4'd0;
            cnt2 <= 4'd0;
        end else if (bus.pair_endp) begin
            if (bus.req[1] && !nxt_gnt[1])
                cnt1 <= (cnt1 == 4'd15) ? cnt1 : cnt1 + 4'd1;
            else
                cnt1 <= 4'd0;
            if (bus.req[2] && !nxt_gnt[2])
                cnt2 <= (cnt2 == 4'd15) ? cnt2 : cnt2 + 4'd1;
            else
                cnt2 <= 4'd0;
        end
    end
`endif
endmodule

// File: tb/tb_slot_pair_arbiter.sv
// Directed bench for slot_pair_arbiter: boundary vector table plus
// hand-written reset, toggle and starvation sequences.
module tb_slot_pair_arbiter;
    logic clk_6M;
    logic rstz;
    int   checks;
    int   errors;

    slot_pair_arbiter_if bus ();

    slot_pair_arbiter dut (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .bus    (bus)
    );

    initial clk_6M = 1'b0;
    always #5 clk_6M = ~clk_6M;

    typedef struct {
        bit         rst;
        logic [2:0] req;
        logic [1:0] l0;
        logic [1:0] l1;
        logic [1:0] l2;
        logic [3:0] lim;
        logic [2:0] eg;
        logic       es;
        logic [1:0] ep;
    } vec_t;

    vec_t v [19];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_6M);
        rstz = 1'b0;
        @(negedge clk_6M);
        rstz = 1'b1;
    endtask

    task automatic boundary(input logic [2:0] r, input logic [1:0] a,
                            input logic [1:0] b, input logic [1:0] c,
                            input logic [3:0] lim);
        @(negedge clk_6M);
        bus.req             = r;
        bus.len0            = a;
        bus.len1            = b;
        bus.len2            = c;
        bus.regi_starve_lim = lim;
        bus.pair_endp       = 1'b1;
        @(posedge clk_6M);
        #1;
        bus.pair_endp = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] g,
                           input logic s, input logic [1:0] p);
        chk({tag, ".gnt"},   32'(bus.gnt), 32'(g));
        chk({tag, ".start"}, 32'(bus.gnt_start_p), 32'(s));
        chk({tag, ".left"},  32'(bus.pairs_left), 32'(p));
        chk({tag, ".busy"},  32'(bus.busy), 32'(|g));
    endtask

    initial begin
        logic [2:0] exp_st;
        checks = 0;
        errors = 0;
        rstz = 1'b0;
        bus.pair_endp = 1'b0;
        bus.req = 3'b000;
        bus.len0 = 2'd0;
        bus.len1 = 2'd0;
        bus.len2 = 2'd0;
        bus.regi_starve_lim = 4'd0;

`ifdef SLOT_ARB_STARVE_EN
        exp_st = 3'b010;
`else
        exp_st = 3'b001;
`endif
        //          rst req     l0 l1 l2 lim  gnt     st pl
        v[0]  = '{1, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0};
        v[1]  = '{0, 3'b001, 2, 0, 0, 0, 3'b001, 1, 2};
        v[2]  = '{0, 3'b001, 2, 0, 0, 0, 3'b001, 0, 1};
        v[3]  = '{0, 3'b001, 2, 0, 0, 0, 3'b001, 0, 0};
        v[4]  = '{0, 3'b001, 2, 0, 0, 0, 3'b001, 1, 2};
        v[5]  = '{1, 3'b110, 0, 0, 0, 0, 3'b010, 1, 0};
        v[6]  = '{0, 3'b110, 0, 0, 0, 0, 3'b100, 1, 0};
        v[7]  = '{0, 3'b110, 0, 0, 0, 0, 3'b010, 1, 0};
        v[8]  = '{1, 3'b001, 3, 0, 0, 0, 3'b001, 1, 3};
        v[9]  = '{0, 3'b001, 3, 0, 0, 0, 3'b001, 0, 2};
        v[10] = '{0, 3'b000, 3, 0, 0, 0, 3'b000, 0, 0};
        v[11] = '{1, 3'b001, 1, 0, 0, 0, 3'b001, 1, 1};
        v[12] = '{0, 3'b001, 3, 0, 0, 0, 3'b001, 0, 0};
        v[13] = '{0, 3'b001, 3, 0, 0, 0, 3'b001, 1, 3};
        v[14] = '{1, 3'b111, 0, 2, 1, 0, 3'b001, 1, 0};
        v[15] = '{1, 3'b011, 0, 0, 0, 3, 3'b001, 1, 0};
        v[16] = '{0, 3'b011, 0, 0, 0, 3, 3'b001, 1, 0};
        v[17] = '{0, 3'b011, 0, 0, 0, 3, 3'b001, 1, 0};
        v[18] = '{0, 3'b011, 0, 0, 0, 3, exp_st, 1, 0};

        repeat (2) @(negedge clk_6M);
        rstz = 1'b1;
        #1;
        chk_out("reset", 3'b000, 1'b0, 2'd0);

        for (int i = 0; i < 19; i++) begin
            if (v[i].rst)
                do_reset();
            boundary(v[i].req, v[i].l0, v[i].l1, v[i].l2, v[i].lim);
            chk_out($sformatf("vec%0d", i), v[i].eg, v[i].es, v[i].ep);
            @(posedge clk_6M);
            #1;
            chk($sformatf("vec%0d.pulse_end", i),
                32'(bus.gnt_start_p), 32'd0);
            chk($sformatf("vec%0d.hold", i), 32'(bus.gnt), 32'(v[i].eg));
            repeat (2) @(posedge clk_6M);
        end

        // asynchronous reset in the middle of a grant
        do_reset();
        boundary(3'b001, 2'd3, 2'd0, 2'd0, 4'd0);
        chk_out("mid.grant", 3'b001, 1'b1, 2'd3);
        @(negedge clk_6M);
        rstz = 1'b0;
        #1;
        chk_out("mid.rst", 3'b000, 1'b0, 2'd0);
        @(negedge clk_6M);
        rstz = 1'b1;
        for (int k = 0; k < 2; k++) begin
            boundary(3'b000, 2'd0, 2'd0, 2'd0, 4'd0);
            chk_out($sformatf("post.rst%0d", k), 3'b000, 1'b0, 2'd0);
        end

        // req and len toggling away from boundaries changes nothing
        do_reset();
        boundary(3'b011, 2'd0, 2'd0, 2'd0, 4'd1);
        chk_out("tog.b0", 3'b001, 1'b1, 2'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_6M);
            bus.req  = 3'(k);
            bus.len0 = 2'(k);
            #1;
            chk($sformatf("tog.gnt%0d", k), 32'(bus.gnt), 32'h1);
            chk($sformatf("tog.left%0d", k), 32'(bus.pairs_left), 32'h0);
        end
        boundary(3'b011, 2'd0, 2'd0, 2'd0, 4'd1);
        chk_out("tog.b1", exp_st, 1'b1, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
